craft_round_constants: RTL and testbench

Round-constant generator for the CRAFT lightweight block cipher datapath. It produces the 8-bit round constant for the current round from two free-running LFSRs: a 4-bit one with period 15 and a 3-bit one with period 7. The round-function block XORs this constant into the state. The round controller advances the generator once per round with a clock-enable.

---
 rtl/craft_round_constants.sv | 26 ++
 tb/tb_craft_round_constants.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/craft_round_constants.sv
// CRAFT round-constant generator: two free-running LFSRs (periods 15 and 7)
// packed into an 8-bit constant, advanced once per round by ce.
module craft_round_constants (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    output logic [7:0] rc
);

    logic [3:0] a;
    logic [2:0] b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a <= 4'b0001;
            b <= 3'b001;
        end else if (ce) begin
            a <= {a[1] ^ a[0], a[3], a[2], a[1]};
            b <= {b[1] ^ b[0], b[2], b[1]};
        end
    end

    // Bit 3 is a constant zero so rc comes straight off the flops.
    assign rc = {a, 1'b0, b};

endmodule

// File: tb/tb_craft_round_constants.sv
// Scoreboard bench for craft_round_constants: stimulus pushes the expected
// constant per edge, a monitor pops and compares after every rising edge.
module tb_craft_round_constants;

    logic       clk;
    logic       rst;
    logic       ce;
    logic [7:0] rc;

    int n_cmp;
    int n_bad;
    int k;

    logic [7:0] expq[$];

    logic [3:0] a_seq [15] = '{4'h1, 4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6,
                               4'hB, 4'h5, 4'hA, 4'hD, 4'hE, 4'hF, 4'h7,
                               4'h3};
    logic [2:0] b_seq [7]  = '{3'd1, 3'd4, 3'd2, 3'd5, 3'd6, 3'd7, 3'd3};
    logic [7:0] rc_tab [16] = '{8'h11, 8'h84, 8'h42, 8'h25, 8'h96, 8'hC7,
                                8'h63, 8'hB1, 8'h54, 8'hA2, 8'hD5, 8'hE6,
                                8'hF7, 8'h73, 8'h31, 8'h14};

    craft_round_constants dut (
        .clk(clk),
        .rst(rst),
        .ce (ce),
        .rc (rc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model(input int n);
        return {a_seq[n % 15], 1'b0, b_seq[n % 7]};
    endfunction

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req,
                     $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // One clock edge of stimulus; the expected post-edge value is queued.
    task automatic step(input logic r, input logic c);
        @(negedge clk);
        rst = r;
        ce  = c;
        if (!r) k = 0;
        else if (c) k++;
        expq.push_back(model(k));
    endtask

    task automatic look();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (expq.size() > 0) begin
            logic [7:0] e;
            e = expq.pop_front();
            chk("scoreboard_rc", rc, e);
            chk("rc_bit3_zero", {7'd0, rc[3]}, 8'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        int fr, fa, fb, na, nb;
        n_cmp = 0;
        n_bad = 0;
        k     = 0;
        rst   = 1'b1;
        ce    = 1'b0;

        // Async reset takes effect before any clock edge.
        #1 rst = 1'b0;
        #1 chk("reset_async", rc, 8'h11);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        // Free run over rounds 1..15 against the published table.
        for (int i = 1; i < 16; i++) begin
            step(1'b1, 1'b1);
            look();
            chk("free_run_tab", rc, rc_tab[i]);
        end

        // Enable gating.
        step(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
            look();
            chk("gate_hold", rc, 8'h25);
        end
        step(1'b1, 1'b1);
        look();
        chk("gate_resume", rc, 8'h96);

        // Mid-run reset pulse between edges.
        step(1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1);
        look();
        chk("pre_pulse", rc, 8'hB1);
        rst = 1'b0;
        k   = 0;
        #1 chk("mid_reset_async", rc, 8'h11);
        #1 rst = 1'b1;
        step(1'b1, 1'b1);
        look();
        chk("post_pulse", rc, 8'h84);

        // Period check.
        step(1'b0, 1'b1);
        fr = 0; fa = 0; fb = 0; na = 0; nb = 0;
        for (int i = 1; i <= 105; i++) begin
            step(1'b1, 1'b1);
            look();
            if (rc == 8'h11 && fr == 0) fr = i;
            if (rc[7:4] == 4'h1) begin
                na++;
                if (fa == 0) fa = i;
            end
            if (rc[2:0] == 3'd1) begin
                nb++;
                if (fb == 0) fb = i;
            end
        end
        chk_int("period_rc", fr, 105);
        chk_int("period_a", fa, 15);
        chk_int("period_b", fb, 7);
        chk_int("count_a_ones", na, 7);
        chk_int("count_b_ones", nb, 15);

        // Random ce against the model.
        step(1'b0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            logic c;
            c = 1'($urandom_range(0, 1));
            step(1'b1, c);
            if ($urandom_range(0, 3) == 0) begin
                // Toggle ce between edges; only the edge value matters.
                #2 ce = ~c;
                #2 ce = c;
            end
        end

        repeat (3) @(posedge clk);
        #3;
        chk_int("queue_drained", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end

endmodule
